maxnet_input_loader: RTL and testbench

MAXNET_INPUT_LOADER -- requirements
Module: maxnet_input_loader

---
 rtl/maxnet_pkg.sv | 25 ++
 rtl/maxnet_f32_check.sv | 27 ++
 rtl/maxnet_input_loader.sv | 135 +++++++++++++
 tb/tb_maxnet_input_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and constants for the MAXNET input loader.
// Optional feature macro used by this slice: MAXNET_CLAMP_NEG_EN.
package maxnet_pkg;

    localparam int DW    = 32;
    localparam int N_ACT = 4;

    localparam logic [31:0] ONE_F32 = 32'h3F800000;
    // Exclusive upper bound for epsilon: 1/N_ACT = 0.25.
    localparam logic [31:0] EPS_MAX = 32'h3E800000;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RUN     = 2'd2
    } maxnet_state_e;

    typedef struct packed {
        maxnet_state_e state;
        logic [2:0]    wcnt;
        logic          eps_ok;
        logic          act_neg;
    } maxnet_dbg_t;

endpackage

// File: rtl/maxnet_f32_check.sv
// Combinational IEEE-754 checks: epsilon range (0 < eps < 1/N_ACT) and negative-activation detect.
// With MAXNET_CLAMP_NEG_EN defined, negative activations are replaced by +0.0.
module maxnet_f32_check
    import maxnet_pkg::*;
#(
    parameter int DW = maxnet_pkg::DW
) (
    input  logic [DW-1:0] word,
    output logic          eps_ok,
    output logic          act_neg,
    output logic [DW-1:0] act_store
);

    logic [DW-2:0] mag;

    // For positive floats the magnitude bits order the same way as the values.
    assign mag     = word[DW-2:0];
    assign eps_ok  = !word[DW-1] && (mag != '0) && (mag < EPS_MAX[DW-2:0]);
    assign act_neg = word[DW-1];

`ifdef MAXNET_CLAMP_NEG_EN
    assign act_store = act_neg ? '0 : word;
`else
    assign act_store = word;
`endif

endmodule

// File: rtl/maxnet_input_loader.sv
// Collects a1..a4 and epsilon from a valid/ready stream, checks framing and epsilon, and hands the vector to the controller.
// Optional negative-activation clamp is enabled by defining MAXNET_CLAMP_NEG_EN.
module maxnet_input_loader
    import maxnet_pkg::*;
#(
    parameter int DW    = maxnet_pkg::DW,
    parameter int N_ACT = maxnet_pkg::N_ACT
) (
    input  logic          clk,
    input  logic          rst,
    // Stream side: a word transfers on a rising edge where s_valid && s_ready.
    // Controller side: the vector transfers on a rising edge where load_valid && load_ready.
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic [DW-1:0] a1_init,
    output logic [DW-1:0] a2_init,
    output logic [DW-1:0] a3_init,
    output logic [DW-1:0] a4_init,
    output logic [DW-1:0] epsilon,
    output logic          load_valid,
    input  logic          load_ready,
    input  logic          finish,
    output logic          err,
    output logic          busy,
    output maxnet_dbg_t   dbg
);

    maxnet_state_e state_q, state_d;
    logic [2:0]    wcnt_q, wcnt_d;
    logic [DW-1:0] act_q [N_ACT];
    logic [DW-1:0] act_d [N_ACT];
    logic [DW-1:0] eps_q, eps_d;
    logic          load_valid_q, load_valid_d;
    logic          err_q, err_d;

    logic          eps_ok;
    logic          act_neg;
    logic [DW-1:0] act_store;
    logic          eps_slot;

    maxnet_f32_check #(.DW(DW)) u_check (
        .word      (s_data),
        .eps_ok    (eps_ok),
        .act_neg   (act_neg),
        .act_store (act_store)
    );

    assign eps_slot = (wcnt_q == 3'(N_ACT));

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        act_d        = act_q;
        eps_d        = eps_q;
        load_valid_d = load_valid_q;
        err_d        = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                if (s_valid) begin
                    // s_last must coincide exactly with the epsilon slot.
                    if (s_last != eps_slot) begin
                        wcnt_d = '0;
                        err_d  = 1'b1;
                    end else if (s_last) begin
                        wcnt_d = '0;
                        if (eps_ok) begin
                            eps_d        = s_data;
                            state_d      = ST_HOLD;
                            load_valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        act_d[wcnt_q[1:0]] = act_store;
                        wcnt_d             = wcnt_q + 3'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (load_ready) begin
                    state_d      = ST_RUN;
                    load_valid_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (finish) begin
                    state_d = ST_COLLECT;
                    wcnt_d  = '0;
                end
            end
            default: begin
                state_d      = ST_COLLECT;
                wcnt_d       = '0;
                load_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_COLLECT;
            wcnt_q       <= '0;
            act_q        <= '{default: '0};
            eps_q        <= '0;
            load_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            act_q        <= act_d;
            eps_q        <= eps_d;
            load_valid_q <= load_valid_d;
            err_q        <= err_d;
        end
    end

    assign s_ready    = (state_q == ST_COLLECT);
    assign busy       = (state_q != ST_COLLECT);
    assign load_valid = load_valid_q;
    assign err        = err_q;
    assign a1_init    = act_q[0];
    assign a2_init    = act_q[1];
    assign a3_init    = act_q[2];
    assign a4_init    = act_q[3];
    assign epsilon    = eps_q;

    assign dbg.state   = state_q;
    assign dbg.wcnt    = wcnt_q;
    assign dbg.eps_ok  = eps_ok;
    assign dbg.act_neg = act_neg;

endmodule

// File: tb/tb_maxnet_input_loader.sv
// Scoreboard bench for maxnet_input_loader: directed frames push expected load/err events, a negedge monitor pops and compares.
// Expected clamp behaviour follows MAXNET_CLAMP_NEG_EN.
module tb_maxnet_input_loader;
    import maxnet_pkg::*;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic [31:0] a1_init, a2_init, a3_init, a4_init, epsilon;
    logic        load_valid;
    logic        load_ready;
    logic        finish;
    logic        err;
    logic        busy;
    maxnet_dbg_t dbg;

    int checks   = 0;
    int failures = 0;

    // Entry layout: [160]=1 for an err event, else {a1,a2,a3,a4,eps} of a load.
    logic [160:0] exp_q[$];
    logic [160:0] mon_e;
    logic         lv_prev;

    maxnet_input_loader dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .a1_init    (a1_init),
        .a2_init    (a2_init),
        .a3_init    (a3_init),
        .a4_init    (a4_init),
        .epsilon    (epsilon),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .finish     (finish),
        .err        (err),
        .busy       (busy),
        .dbg        (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] act_exp(input logic [31:0] w);
`ifdef MAXNET_CLAMP_NEG_EN
        return w[31] ? 32'h0 : w;
`else
        return w;
`endif
    endfunction

    // Monitor: outputs are registered, so sampling on the falling edge is race-free.
    always @(negedge clk) begin
        if (!rst) begin
            lv_prev = 1'b0;
        end else begin
            if (err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_err_qsize", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("err_event_kind", 32'(mon_e[160]), 32'd1);
                end
            end
            if (load_valid && !lv_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_load_qsize", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("load_event_kind", 32'(mon_e[160]), 32'd0);
                    check("load_a1", a1_init, mon_e[159:128]);
                    check("load_a2", a2_init, mon_e[127:96]);
                    check("load_a3", a3_init, mon_e[95:64]);
                    check("load_a4", a4_init, mon_e[63:32]);
                    check("load_eps", epsilon, mon_e[31:0]);
                end
            end
            lv_prev = load_valid;
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic push_err();
        exp_q.push_back({1'b1, 160'h0});
    endtask

    task automatic good_frame(input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                              input logic [31:0] w4, input logic [31:0] e);
        exp_q.push_back({1'b0, act_exp(w1), act_exp(w2), act_exp(w3), act_exp(w4), e});
        beat(w1, 1'b0);
        beat(w2, 1'b0);
        beat(w3, 1'b0);
        beat(w4, 1'b0);
        beat(e, 1'b1);
        check("load_valid_latency", 32'(load_valid), 32'd1);
        check("state_hold", 32'(dbg.state), 32'(ST_HOLD));
        check("no_err_good", 32'(err), 32'd0);
        check("s_ready_hold", 32'(s_ready), 32'd0);
    endtask

    task automatic bad_eps_frame(input logic [31:0] e);
        push_err();
        beat(32'h3F800000, 1'b0);
        beat(32'h3F800000, 1'b0);
        beat(32'h3F800000, 1'b0);
        beat(32'h3F800000, 1'b0);
        beat(e, 1'b1);
        check("bad_eps_err", 32'(err), 32'd1);
        check("bad_eps_state", 32'(dbg.state), 32'(ST_COLLECT));
        check("bad_eps_no_load", 32'(load_valid), 32'd0);
        tick();
        check("bad_eps_err_pulse", 32'(err), 32'd0);
    endtask

    task automatic complete_run();
        load_ready = 1'b1;
        tick();
        load_ready = 1'b0;
        check("run_state", 32'(dbg.state), 32'(ST_RUN));
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("collect_after_finish", 32'(dbg.state), 32'(ST_COLLECT));
    endtask

    initial begin
        rst        = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        load_ready = 1'b0;
        finish     = 1'b0;
        lv_prev    = 1'b0;
        tick();
        tick();

        check("rst_state", 32'(dbg.state), 32'(ST_COLLECT));
        check("rst_wcnt", 32'(dbg.wcnt), 32'd0);
        check("rst_a1", a1_init, 32'h0);
        check("rst_eps", epsilon, 32'h0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();
        check("rst_s_ready", 32'(s_ready), 32'd1);

        // Nominal frame, then the handshake with a stalled controller.
        good_frame(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40400000, 32'h3DCCCCCD);
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 32'hDEADBEEF;
            finish  = (i == 5);
            tick();
            check("hold_load_valid", 32'(load_valid), 32'd1);
            check("hold_s_ready", 32'(s_ready), 32'd0);
            check("hold_state", 32'(dbg.state), 32'(ST_HOLD));
        end
        s_valid = 1'b0;
        finish  = 1'b0;
        check("hold_a1_stable", a1_init, 32'h3F800000);
        check("hold_eps_stable", epsilon, 32'h3DCCCCCD);
        load_ready = 1'b1;
        tick();
        check("run_state", 32'(dbg.state), 32'(ST_RUN));
        check("run_load_valid", 32'(load_valid), 32'd0);
        check("run_busy", 32'(busy), 32'd1);
        check("run_s_ready", 32'(s_ready), 32'd0);
        tick();
        load_ready = 1'b0;
        // Beat offered together with finish must not be taken.
        s_valid = 1'b1;
        s_data  = 32'h41200000;
        finish  = 1'b1;
        tick();
        s_valid = 1'b0;
        finish  = 1'b0;
        check("finish_state", 32'(dbg.state), 32'(ST_COLLECT));
        check("finish_s_ready", 32'(s_ready), 32'd1);
        check("finish_busy", 32'(busy), 32'd0);
        check("finish_wcnt", 32'(dbg.wcnt), 32'd0);
        check("finish_a1_kept", a1_init, 32'h3F800000);
        check("finish_a4_kept", a4_init, 32'h40400000);

        // Early last on the 3rd beat, then a good frame.
        push_err();
        beat(32'h3F800000, 1'b0);
        beat(32'h3F800000, 1'b0);
        beat(32'h3F800000, 1'b1);
        check("early_last_err", 32'(err), 32'd1);
        check("early_last_wcnt", 32'(dbg.wcnt), 32'd0);
        check("early_last_no_load", 32'(load_valid), 32'd0);
        tick();
        check("early_last_pulse", 32'(err), 32'd0);
        good_frame(32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h3E000000);
        complete_run();

        // Missing last on the 5th beat.
        push_err();
        for (int i = 0; i < 5; i++) beat(32'h3F000000, 1'b0);
        check("late_last_err", 32'(err), 32'd1);
        check("late_last_state", 32'(dbg.state), 32'(ST_COLLECT));
        tick();

        // Epsilon range boundaries.
        bad_eps_frame(32'h3E800000);
        bad_eps_frame(32'h80000000);
        bad_eps_frame(32'h00000000);
        good_frame(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3E7FFFFF);
        complete_run();

        // Negative activations.
        good_frame(32'hBF800000, 32'h40000000, 32'hC0000000, 32'h3F000000, 32'h3DCCCCCD);
`ifdef MAXNET_CLAMP_NEG_EN
        check("clamp_a1", a1_init, 32'h00000000);
`else
        check("clamp_a1", a1_init, 32'hBF800000);
`endif
        complete_run();

        // Reset mid-frame abandons the partial frame without err.
        beat(32'h40000000, 1'b0);
        beat(32'h40000000, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst_frame_wcnt", 32'(dbg.wcnt), 32'd0);
        check("rst_frame_err", 32'(err), 32'd0);
        good_frame(32'h3F000000, 32'h3F400000, 32'h3F800000, 32'h3FC00000, 32'h3D800000);

        // Reset in RUN.
        load_ready = 1'b1;
        tick();
        load_ready = 1'b0;
        check("pre_rst_run", 32'(dbg.state), 32'(ST_RUN));
        rst = 1'b0;
        tick();
        check("rst_run_state", 32'(dbg.state), 32'(ST_COLLECT));
        check("rst_run_a1", a1_init, 32'h0);
        check("rst_run_a2", a2_init, 32'h0);
        check("rst_run_a3", a3_init, 32'h0);
        check("rst_run_a4", a4_init, 32'h0);
        check("rst_run_eps", epsilon, 32'h0);
        check("rst_run_load_valid", 32'(load_valid), 32'd0);
        check("rst_run_err", 32'(err), 32'd0);
        check("rst_run_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();
        check("rst_run_s_ready", 32'(s_ready), 32'd1);
        check("rst_run_no_err", 32'(err), 32'd0);

        tick();
        tick();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
